z80_vector_int_ctrl: RTL



---
 rtl/z80_vector_int_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/z80_vector_int_ctrl.sv
// Z80 mode-2 vectored interrupt controller: eight prioritised sources, mask/pending/vector-base registers.
// Define INTCTL_EDGE_EN for edge-latched pending bits; the default build is level mode.
module z80_vector_int_ctrl #(
    parameter logic [7:0] INT_BASE_PORT = 8'hA0
) (
    input  logic       pll0_250MHz,
    input  logic       reset,
    input  logic [7:0] irqIn,
    input  logic       z80_m1_n,
    input  logic       z80_iorq_n,
    input  logic       z80_rd_n,
    input  logic       z80_wr_n,
    input  logic [7:0] cpuAdr,
    input  logic [7:0] cpuDataOut,
    output logic       z80_int_n,
    output logic [7:0] intsToCpu,
    output logic       intVectToCPU_cs
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, SERVICE} stateT;

    stateT state, stateNext;

    logic [7:0] irqS1, irqS2;
    logic [3:0] strobeS1, strobeS2;
    logic       m1S, iorqS, rdS, wrS;
    logic       intaActive, iordActive, iowrActive;
    logic       intaPrev, iowrPrev;
    logic       intaFall, intaRise, iowrFall;

    logic [7:0] mask, pend, act;
    logic [3:0] vbaseHi;
    logic       isv;
    logic [2:0] insvc;

    logic       portHit;
    logic [1:0] regSel;
    logic       wrMask, wrVbase, eoiWr;
    logic       actAny, captureValid, ackTake;
    logic [2:0] winIdx;
    logic [7:0] vecSel, readMux;
    logic       intNNext;

    function automatic logic [2:0] lowestIdx(input logic [7:0] v);
        lowestIdx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lowestIdx = 3'(i);
    endfunction

    // Strobes are stored active-high after synchronisation: {m1, iorq, rd, wr}.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            irqS1    <= 8'h00;
            irqS2    <= 8'h00;
            strobeS1 <= 4'b0000;
            strobeS2 <= 4'b0000;
            intaPrev <= 1'b0;
            iowrPrev <= 1'b0;
        end else begin
            irqS1    <= irqIn;
            irqS2    <= irqS1;
            strobeS1 <= ~{z80_m1_n, z80_iorq_n, z80_rd_n, z80_wr_n};
            strobeS2 <= strobeS1;
            intaPrev <= intaActive;
            iowrPrev <= iowrActive;
        end
    end

    assign {m1S, iorqS, rdS, wrS} = strobeS2;
    assign intaActive = m1S & iorqS;
    assign iordActive = iorqS & rdS & ~m1S;
    assign iowrActive = iorqS & wrS & ~m1S;
    assign intaFall   = intaActive & ~intaPrev;
    assign intaRise   = ~intaActive & intaPrev;
    assign iowrFall   = iowrActive & ~iowrPrev;

    assign portHit = (cpuAdr[7:2] == INT_BASE_PORT[7:2]);
    assign regSel  = cpuAdr[1:0];
    assign wrMask  = iowrFall & portHit & (regSel == 2'd0);
    assign wrVbase = iowrFall & portHit & (regSel == 2'd2);
    assign eoiWr   = iowrFall & portHit & (regSel == 2'd3);

    assign act          = pend & mask;
    assign actAny       = |act;
    assign winIdx       = lowestIdx(act);
    assign captureValid = (state == REQ) && actAny;
    assign ackTake      = intaFall & captureValid;
    assign vecSel       = captureValid ? {vbaseHi, winIdx, 1'b0} : {vbaseHi, 3'b111, 1'b0};

`ifdef INTCTL_EDGE_EN
    logic [7:0] irqPrev, irqRise, w1cBits, ackBits;
    logic       wrPend;

    assign wrPend  = iowrFall & portHit & (regSel == 2'd1);
    assign irqRise = irqS2 & ~irqPrev;
    assign w1cBits = wrPend ? cpuDataOut : 8'h00;
    assign ackBits = ackTake ? (8'h01 << winIdx) : 8'h00;

    // Clears are applied before the OR so a same-clock new edge survives.
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            irqPrev <= 8'h00;
            pend    <= 8'h00;
        end else begin
            irqPrev <= irqS2;
            pend    <= (pend & ~w1cBits & ~ackBits) | irqRise;
        end
    end
`else
    always_ff @(posedge pll0_250MHz) begin
        if (reset) pend <= 8'h00;
        else       pend <= irqS2;
    end
`endif

    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            mask    <= 8'h00;
            vbaseHi <= 4'h0;
            isv     <= 1'b0;
            insvc   <= 3'd0;
        end else begin
            if (wrMask)  mask    <= cpuDataOut;
            if (wrVbase) vbaseHi <= cpuDataOut[7:4];
            if (ackTake) begin
                isv   <= 1'b1;
                insvc <= winIdx;
            end else if (eoiWr && state == SERVICE) begin
                isv <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        readMux = 8'h00;
        case (regSel)
            2'd0: readMux = mask;
            2'd1: readMux = pend;
            2'd2: readMux = {vbaseHi, 4'h0};
            2'd3: readMux = {isv, 4'h0, insvc};
            default: readMux = 8'h00;
        endcase
    end

    // The vector is frozen at the INTA falling edge and held until the strobe ends.
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            intsToCpu       <= 8'h00;
            intVectToCPU_cs <= 1'b0;
        end else if (intaActive) begin
            if (intaFall) intsToCpu <= vecSel;
            intVectToCPU_cs <= 1'b1;
        end else if (iordActive && portHit) begin
            intsToCpu       <= readMux;
            intVectToCPU_cs <= 1'b1;
        end else begin
            intsToCpu       <= 8'h00;
            intVectToCPU_cs <= 1'b0;
        end
    end

    always_ff @(posedge pll0_250MHz) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (actAny) stateNext = REQ;
            REQ:     if (intaFall) stateNext = ACK;
                     else if (!actAny) stateNext = IDLE;
            ACK:     if (intaRise) stateNext = isv ? SERVICE : IDLE;
            SERVICE: if (eoiWr) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        intNNext = (state != REQ);
    end

    always_ff @(posedge pll0_250MHz) begin
        if (reset) z80_int_n <= 1'b1;
        else       z80_int_n <= intNNext;
    end

endmodule
